// File: rtl/conv_stream_feeder_if.sv
// Handshake bundle between the stream feeder (master) and the convolution accelerator (slave).
// A beat moves on every rising clk edge where valid && ready; once valid rises, valid and data hold until that edge.
interface conv_stream_feeder_if #(
  parameter int DW = 32
);
  logic          ifm_valid;
  logic [DW-1:0] ifm_data;
  logic          ifm_ready;
  logic          wht_valid;
  logic [DW-1:0] wht_data;
  logic          wht_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;

  modport master (
    output ifm_valid, ifm_data, wht_valid, wht_data, out_ready,
    input  ifm_ready, wht_ready, out_valid, out_data
  );

  modport slave (
    input  ifm_valid, ifm_data, wht_valid, wht_data, out_ready,
    output ifm_ready, wht_ready, out_valid, out_data
  );
endinterface

// File: rtl/conv_stream_feeder.sv
// Per pass: kick the accelerator, stream IFM then weight beats from the source buffer
// through a 2-entry fall-through prefetch FIFO, then drain result beats into the sink.
module conv_stream_feeder #(
  parameter int            KERNEL_SIZE = 3,
  parameter int            CHANNELS    = 4,
  parameter int            PAD         = 1,
  parameter int            KERNEL_NUM  = 2,
  parameter int            PE_COLS     = 8,
  parameter int            IFM_SIZE    = 56,
  parameter int            DW          = 32,
  parameter int            AW          = 14,
  parameter logic [AW-1:0] WHT_BASE    = 14'h3000,
  parameter int            OUT_BEATS   = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [5:0]    n_pass,
  output logic          src_rd_en,
  output logic [AW-1:0] src_rd_addr,
  input  logic [DW-1:0] src_rd_data,
  output logic          conv_start,
  conv_stream_feeder_if.master acc,
  output logic          sink_wr_en,
  output logic [AW-1:0] sink_wr_addr,
  output logic [DW-1:0] sink_wr_data,
  output logic          busy,
  output logic          done,
  output logic [2:0]    dbg_state
);
  localparam int IFM_BEATS = (IFM_SIZE + 2*PAD) * (KERNEL_SIZE + PE_COLS - 1) * CHANNELS / 4;
  localparam int WHT_BEATS = KERNEL_SIZE * KERNEL_SIZE * KERNEL_NUM * CHANNELS / 4;
  localparam int MAXB = (IFM_BEATS > WHT_BEATS)
                      ? ((IFM_BEATS > OUT_BEATS) ? IFM_BEATS : OUT_BEATS)
                      : ((WHT_BEATS > OUT_BEATS) ? WHT_BEATS : OUT_BEATS);
  localparam int CW = $clog2(MAXB + 1);
  localparam logic [CW-1:0] IFM_LAST = CW'(IFM_BEATS - 1);
  localparam logic [CW-1:0] IFM_N    = CW'(IFM_BEATS);
  localparam logic [CW-1:0] WHT_N    = CW'(WHT_BEATS);
  localparam logic [CW-1:0] OUT_LAST = CW'(OUT_BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_KICK, S_SEND_IFM, S_SEND_WHT, S_DRAIN, S_FIN
  } state_t;

  state_t        state, state_nx;
  logic [5:0]    n_pass_q, pass_cnt;
  logic [CW-1:0] beat_cnt, out_cnt;
  logic [AW-1:0] ifm_ptr, wht_ptr, sink_ptr;
  logic [DW:0]   fifo_mem [2];
  logic          rd_ptr, wr_ptr;
  logic [1:0]    count;
  logic          inflight, inflight_tag;

  logic [DW:0]   head_entry;
  logic          head_valid, ifm_v, wht_v, pop;
  logic          phase_left, issue, store_push, store_pop;
  logic          out_fire, last_out, more_pass;

  // The read returning this cycle acts as the FIFO head when nothing is stored,
  // which keeps one beat per cycle with no extra latency.
  always_comb begin
    head_entry = (count != 2'd0) ? fifo_mem[rd_ptr] : {inflight_tag, src_rd_data};
    head_valid = (count != 2'd0) || inflight;
    ifm_v      = head_valid && !head_entry[DW];
    wht_v      = head_valid &&  head_entry[DW];
    pop        = (ifm_v && acc.ifm_ready) || (wht_v && acc.wht_ready);
    phase_left = ((state == S_SEND_IFM) && (beat_cnt < IFM_N)) ||
                 ((state == S_SEND_WHT) && (beat_cnt < WHT_N));
    issue      = phase_left && ((({1'b0, count} + {2'b00, inflight}) < 3'd2) || pop);
    store_push = inflight && !((count == 2'd0) && pop);
    store_pop  = pop && (count != 2'd0);
    out_fire   = (state == S_DRAIN) && acc.out_valid;
    last_out   = out_fire && (out_cnt == OUT_LAST);
    more_pass  = ({1'b0, pass_cnt} + 7'd1) < {1'b0, n_pass_q};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (start) state_nx = S_KICK;
      S_KICK:     state_nx = S_SEND_IFM;
      S_SEND_IFM: if (issue && (beat_cnt == IFM_LAST)) state_nx = S_SEND_WHT;
      S_SEND_WHT: if ((beat_cnt == WHT_N) && (count == 2'd0) && !inflight) state_nx = S_DRAIN;
      S_DRAIN:    if (last_out) state_nx = more_pass ? S_KICK : S_FIN;
      S_FIN:      state_nx = S_IDLE;
      default:    state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    src_rd_en     = issue;
    src_rd_addr   = issue ? ((state == S_SEND_WHT) ? wht_ptr : ifm_ptr) : '0;
    conv_start    = (state == S_KICK);
    busy          = (state != S_IDLE);
    done          = (state == S_FIN);
    acc.ifm_valid = ifm_v;
    acc.ifm_data  = ifm_v ? head_entry[DW-1:0] : '0;
    acc.wht_valid = wht_v;
    acc.wht_data  = wht_v ? head_entry[DW-1:0] : '0;
    acc.out_ready = (state == S_DRAIN);
    sink_wr_en    = out_fire;
    sink_wr_addr  = sink_ptr;
    sink_wr_data  = out_fire ? acc.out_data : '0;
    dbg_state     = state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      n_pass_q     <= '0;
      pass_cnt     <= '0;
      beat_cnt     <= '0;
      out_cnt      <= '0;
      ifm_ptr      <= '0;
      wht_ptr      <= '0;
      sink_ptr     <= '0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      count        <= '0;
      inflight     <= 1'b0;
      inflight_tag <= 1'b0;
    end else begin
      if ((state == S_IDLE) && start) begin
        n_pass_q <= (n_pass == 6'd0) ? 6'd1 : n_pass;
        pass_cnt <= '0;
        ifm_ptr  <= '0;
        wht_ptr  <= WHT_BASE;
        sink_ptr <= '0;
      end
      if ((state == S_KICK) || ((state == S_SEND_IFM) && (state_nx == S_SEND_WHT)))
        beat_cnt <= '0;
      else if (issue)
        beat_cnt <= beat_cnt + CW'(1);
      if (issue) begin
        if (state == S_SEND_WHT) wht_ptr <= wht_ptr + AW'(1);
        else                     ifm_ptr <= ifm_ptr + AW'(1);
      end
      inflight     <= issue;
      inflight_tag <= (state == S_SEND_WHT);
      if (store_push) wr_ptr <= ~wr_ptr;
      if (store_pop)  rd_ptr <= ~rd_ptr;
      case ({store_push, store_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (state == S_KICK) out_cnt <= '0;
      else if (out_fire)   out_cnt <= out_cnt + CW'(1);
      if (out_fire) sink_ptr <= sink_ptr + AW'(1);
      if (last_out) pass_cnt <= pass_cnt + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (store_push) fifo_mem[wr_ptr] <= {inflight_tag, src_rd_data};
  end
endmodule

// File: doc/conv_stream_feeder.md
# conv_stream_feeder

Host-side streaming source and result sink for the convolution controller. Per pass it pulses `conv_start`, streams one IFM batch and one weight batch from a source buffer over the `ifm_*` / `wht_*` valid/ready channels, then drains the result beats the accelerator presents on `out_valid` into a sink buffer. It repeats this for `n_pass` passes and then reports `done`. It is the transmitter for the accelerator's SRAM-load inputs and the receiver for its output channel.

## Interface

**Parameters**
- `KERNEL_SIZE`, default 3: kernel width/height.
- `CHANNELS`, default 4: channels per group; each beat carries 4 channels.
- `PAD`, default 1: spatial padding.
- `KERNEL_NUM`, default 2: kernels per weight batch.
- `PE_COLS`, default 8: PE columns.
- `IFM_SIZE`, default 56: IFM width.
- `DW`, default 32: beat width (4 × 8-bit).
- `AW`, default 14: source and sink address width.
- `WHT_BASE`, default 14'h3000: start of the weight region in the source buffer.
- `OUT_BEATS`, default 16: result beats per pass.
- Derived: `IFM_BEATS = (IFM_SIZE+2*PAD)*(KERNEL_SIZE+PE_COLS-1)*CHANNELS/4` (580 at defaults).
- Derived: `WHT_BEATS = KERNEL_SIZE*KERNEL_SIZE*KERNEL_NUM*CHANNELS/4` (18 at defaults).

**Ports** (name, direction, width, meaning)
- `clk` in 1: single clock, all logic on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: begin a job; sampled only in IDLE.
- `n_pass` in 6: number of passes (0 is treated as 1); latched on `start`.
- `src_rd_en` out 1: source read strobe.
- `src_rd_addr` out AW: source read address.
- `src_rd_data` in DW: source read data, valid exactly 1 cycle after `src_rd_en`.
- `conv_start` out 1: one-cycle pulse per pass.
- `ifm_valid` out 1, `ifm_data` out DW, `ifm_ready` in 1: IFM channel.
- `wht_valid` out 1, `wht_data` out DW, `wht_ready` in 1: weight channel.
- `out_valid` in 1, `out_data` in DW, `out_ready` out 1: result channel.
- `sink_wr_en` out 1, `sink_wr_addr` out AW, `sink_wr_data` out DW: result sink write port.
- `busy` out 1: high whenever not in IDLE.
- `done` out 1: one-cycle pulse when the job completes.

## Operation

- **States**
  - IDLE –`start`→ KICK.
  - KICK (1 cycle) → SEND_IFM.
  - SEND_IFM → SEND_WHT once `IFM_BEATS` reads are issued.
  - SEND_WHT → DRAIN once `WHT_BEATS` reads are issued **and** the FIFO is empty with nothing in flight.
  - DRAIN → KICK when `OUT_BEATS` beats are accepted and passes remain; otherwise → FIN.
  - FIN (1 cycle, `done`=1) → IDLE.
- **Prefetch FIFO**
  - 2 entries, each `{tag, data}`; tag 0 = IFM, 1 = weight.
  - Read data is pushed the cycle after `src_rd_en`, tagged with the phase at issue.
  - `ifm_valid` = FIFO non-empty & head tag 0; `ifm_data` = head data.
  - `wht_valid` = FIFO non-empty & head tag 1; `wht_data` = head data.
  - A pop occurs on `ifm_valid & ifm_ready` or `wht_valid & wht_ready`.
- **Read issue**
  - Issue only in SEND_IFM or SEND_WHT with beats remaining, and only when `count + inflight < 2` or a pop occurs in the same cycle.
  - The FIFO never overflows; push and pop in the same cycle are legal.
- **Source addresses**
  - IFM pointer starts at 0 and increments per IFM read, continuing across passes.
  - Weight pointer starts at `WHT_BASE` and increments per weight read, continuing across passes.
  - Both pointers reset only on `start` or `rst`; they wrap modulo 2^AW silently.
- **Drain**
  - `out_ready` = 1 in DRAIN only.
  - Each `out_valid & out_ready` produces `sink_wr_en`=1 with `sink_wr_data`=`out_data` in the same cycle (combinational pass-through) and `sink_wr_addr` = sink pointer.
  - The sink pointer starts at 0 on `start` and increments per beat.
- **Pass counter**: counts completed DRAINs and compares against the latched `n_pass`.
- **`start` while busy**: ignored.
- **`rst` asserted mid-job**: the next edge returns to IDLE, empties the FIFO, discards in-flight data and zeroes all pointers and counters; a read completing after reset is not pushed.

## Timing

- **Reset values**: all outputs 0 (`src_rd_en`, `conv_start`, `ifm_valid`, `wht_valid`, `out_ready`, `sink_wr_en`, `busy`, `done`, all addresses and data).
- **Start-up**: `start` high in cycle T (IDLE) → `conv_start`=1 and `busy`=1 in T+1 → first `src_rd_en` (addr 0) in T+2 → `ifm_valid`=1 in T+3.
- **Throughput**: with ready held high, one beat per cycle. The IFM stream takes 580 consecutive cycles, and the first weight beat follows the last IFM beat with no bubble.
- **Backpressure**: while a ready is low, `valid`/`data` stay stable and at most 2 reads are outstanding.
- **Pass turnaround**: the last accepted output beat in cycle D → `conv_start` in D+1 (next pass) or `done` in D+1 (final pass), then `busy`=0 in D+2.

## Test plan

1. **Single pass, ready always high.** `n_pass`=1, `start`. Expect: one `conv_start`; IFM beats 0..579 on source addresses 0..579 contiguous; weight beats from 0x3000..0x3011; 16 output beats written to sink addresses 0..15; `done` 1 cycle after the last output beat.
2. **Random backpressure.** Toggle `ifm_ready`/`wht_ready` pseudo-randomly. Expect: the data sequence is identical to test 1, with no drop or duplicate, and `src_rd_en` is never issued while `count+inflight`=2 with no pop.
3. **Three passes.** `n_pass`=3. Expect: 3 `conv_start` pulses; second pass IFM addresses 580..1159 and weight addresses 0x3012..0x3023; sink addresses 0..47; a single `done`.
4. **`n_pass`=0.** Expect: behaves exactly as `n_pass`=1.
5. **Reset during SEND_WHT with a read in flight.** Expect: IDLE on the next edge, all outputs 0, and no stale weight beat after a following `start` (first beat is IFM address 0).
6. **`start` pulsed during DRAIN.** Expect: ignored; the pass count and pointers are unaffected.
